// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// register-address width and the load-use detection helper.
package hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 3;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 3'd0;

    typedef enum logic {
        RUN    = 1'b0,
        FREEZE = 1'b1
    } state_e;

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    function automatic logic is_load_use(
        input logic      ex_mem_read,
        input reg_addr_t ex_rt,
        input reg_addr_t id_rs,
        input reg_addr_t id_rt,
        input logic      id_uses_rs,
        input logic      id_uses_rt
    );
        return ex_mem_read && (ex_rt != REG_ZERO) &&
               ((id_uses_rs && (ex_rt == id_rs)) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: hazard sources in,
// register enables / squash controls and performance counters out.
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);
    reg_addr_t          id_rs;
    reg_addr_t          id_rt;
    logic               id_uses_rs;
    logic               id_uses_rt;
    logic               ex_mem_read;
    reg_addr_t          ex_rt;
    logic               ex_branch_taken;
    logic               mem_access;
    logic               mem_ready;

    logic               pc_en;
    logic               if_id_en;
    logic               id_ex_en;
    logic               ex_mem_en;
    logic               id_ex_bubble;
    logic               if_id_flush;
    logic               pc_redirect;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
               ex_branch_taken, mem_access, mem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, id_ex_bubble, if_id_flush,
               pc_redirect, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
               ex_branch_taken, mem_access, mem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, id_ex_bubble, if_id_flush,
               pc_redirect, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: increments on inc, holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / taken-branch / data-memory-wait stall controller for the
// five-stage pipeline; control outputs are combinational from state and inputs.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hif
);
    state_e state_q;
    state_e state_d;
    logic   flush_pend_q;
    logic   flush_pend_d;
    logic   stall_inc;
    logic   flush_inc;
    logic   mem_wait;
    logic   load_use;

    assign mem_wait = hif.mem_access && !hif.mem_ready;
    assign load_use = is_load_use(hif.ex_mem_read, hif.ex_rt, hif.id_rs, hif.id_rt,
                                  hif.id_uses_rs, hif.id_uses_rt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        flush_pend_d     = flush_pend_q;
        hif.pc_en        = 1'b1;
        hif.if_id_en     = 1'b1;
        hif.id_ex_en     = 1'b1;
        hif.ex_mem_en    = 1'b1;
        hif.id_ex_bubble = 1'b0;
        hif.if_id_flush  = 1'b0;
        hif.pc_redirect  = 1'b0;
        stall_inc        = 1'b0;
        flush_inc        = 1'b0;

        if (rst) begin
            // Squash whatever is in flight while the core comes out of reset
            hif.id_ex_bubble = 1'b1;
            hif.if_id_flush  = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mem_wait) begin
                        hif.pc_en     = 1'b0;
                        hif.if_id_en  = 1'b0;
                        hif.id_ex_en  = 1'b0;
                        hif.ex_mem_en = 1'b0;
                        flush_pend_d  = hif.ex_branch_taken;
                        stall_inc     = 1'b1;
                        state_d       = FREEZE;
                    end else if (hif.ex_branch_taken) begin
                        hif.if_id_flush  = 1'b1;
                        hif.id_ex_bubble = 1'b1;
                        hif.pc_redirect  = 1'b1;
                        flush_inc        = 1'b1;
                    end else if (load_use) begin
                        hif.pc_en        = 1'b0;
                        hif.if_id_en     = 1'b0;
                        hif.id_ex_bubble = 1'b1;
                        stall_inc        = 1'b1;
                    end
                end
                FREEZE: begin
                    if (mem_wait) begin
                        hif.pc_en     = 1'b0;
                        hif.if_id_en  = 1'b0;
                        hif.id_ex_en  = 1'b0;
                        hif.ex_mem_en = 1'b0;
                        flush_pend_d  = flush_pend_q || hif.ex_branch_taken;
                        stall_inc     = 1'b1;
                    end else begin
                        // A branch seen during the freeze redirects exactly once, here
                        if (flush_pend_q || hif.ex_branch_taken) begin
                            hif.if_id_flush  = 1'b1;
                            hif.id_ex_bubble = 1'b1;
                            hif.pc_redirect  = 1'b1;
                            flush_inc        = 1'b1;
                        end
                        flush_pend_d = 1'b0;
                        state_d      = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (hif.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (hif.flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: per-cycle expected control vectors are
// queued when inputs are driven and compared at the following falling edge.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int unsigned CNT_W = 16;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, id_ex_bubble, if_id_flush, pc_redirect}
    localparam logic [6:0] NORM = 7'b1111_000;
    localparam logic [6:0] LU   = 7'b0011_100;
    localparam logic [6:0] BR   = 7'b1111_111;
    localparam logic [6:0] FRZ  = 7'b0000_000;
    localparam logic [6:0] RSTV = 7'b1111_110;

    typedef struct packed {
        logic      rst;
        reg_addr_t rs;
        reg_addr_t rt;
        logic      urs;
        logic      urt;
        logic      mrd;
        reg_addr_t ert;
        logic      br;
        logic      macc;
        logic      mrdy;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [6:0] exp_q[$];

    hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic stim_t mk(input reg_addr_t rs, input reg_addr_t rt, input logic urs,
                                 input logic urt, input logic mrd, input reg_addr_t ert,
                                 input logic br, input logic macc, input logic mrdy);
        stim_t s;
        s.rst = 1'b0; s.rs = rs; s.rt = rt; s.urs = urs; s.urt = urt;
        s.mrd = mrd; s.ert = ert; s.br = br; s.macc = macc; s.mrdy = mrdy;
        return s;
    endfunction

    function automatic stim_t with_rst(input stim_t s);
        stim_t r = s;
        r.rst = 1'b1;
        return r;
    endfunction

    task automatic apply(input stim_t s);
        rst                 = s.rst;
        hif.id_rs           = s.rs;
        hif.id_rt           = s.rt;
        hif.id_uses_rs      = s.urs;
        hif.id_uses_rt      = s.urt;
        hif.ex_mem_read     = s.mrd;
        hif.ex_rt           = s.ert;
        hif.ex_branch_taken = s.br;
        hif.mem_access      = s.macc;
        hif.mem_ready       = s.mrdy;
    endtask

    // Called just after a rising edge; returns just after the next rising edge.
    task automatic cycle(input string tag, input stim_t s, input logic [6:0] exp);
        logic [6:0] want;
        logic [6:0] got;
        apply(s);
        exp_q.push_back(exp);
        @(negedge clk);
        got = {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en,
               hif.id_ex_bubble, hif.if_id_flush, hif.pc_redirect};
        want = exp_q.pop_front();
        check(tag, 32'(got), 32'(want));
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input logic [CNT_W-1:0] st, input logic [CNT_W-1:0] fl);
        check({tag, ".stall"}, 32'(hif.stall_cnt), 32'(st));
        check({tag, ".flush"}, 32'(hif.flush_cnt), 32'(fl));
    endtask

    stim_t idle;
    stim_t wait_s;
    stim_t lu_s;

    initial begin
        idle   = mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        wait_s = mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        lu_s   = mk(3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1);
        apply(with_rst(idle));
        @(posedge clk);
        #1;

        // Reset values
        cycle("rst0", with_rst(idle), RSTV);
        check_cnt("rst0", 16'd0, 16'd0);
        cycle("idle", idle, NORM);

        // Load-use on rs: one stall cycle, then the load has moved on
        cycle("lu_rs", lu_s, LU);
        cycle("lu_after", idle, NORM);
        check_cnt("lu", 16'd1, 16'd0);
        cycle("lu_rt", mk(3'd0, 3'd5, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1), LU);
        check_cnt("lu_rt", 16'd2, 16'd0);

        // r0 destination and unused source never stall
        cycle("lu_r0", mk(3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1), NORM);
        cycle("lu_unused", mk(3'd0, 3'd3, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1), NORM);
        check_cnt("no_lu", 16'd2, 16'd0);

        // Branch overrides a coincident load-use
        cycle("rst1", with_rst(idle), RSTV);
        cycle("br_lu", mk(3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1), BR);
        cycle("br_after", idle, NORM);
        check_cnt("br_lu", 16'd0, 16'd1);

        // Three-cycle memory wait, release on the fourth
        cycle("rst2", with_rst(idle), RSTV);
        for (int i = 0; i < 3; i++) cycle($sformatf("mw%0d", i), wait_s, FRZ);
        cycle("mw_rel", mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1), NORM);
        cycle("mw_after", idle, NORM);
        check_cnt("mw", 16'd3, 16'd0);

        // Branch arriving mid-freeze redirects once, on release
        cycle("rst3", with_rst(idle), RSTV);
        cycle("fb_w0", wait_s, FRZ);
        cycle("fb_w1", mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0), FRZ);
        cycle("fb_rel", mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1), BR);
        cycle("fb_after", idle, NORM);
        check_cnt("fb", 16'd2, 16'd1);

        // Branch present on freeze entry then gone at release: pending flag still redirects
        cycle("pb_w0", mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0), FRZ);
        cycle("pb_rel", mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1), BR);
        cycle("pb_after", idle, NORM);
        check_cnt("pb", 16'd3, 16'd2);

        // Load-use is ignored on the release cycle
        cycle("rl_w0", wait_s, FRZ);
        cycle("rl_rel", mk(3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1), NORM);
        check_cnt("rl", 16'd4, 16'd2);

        // Reset in FREEZE: no redirect, back to RUN with counters cleared
        cycle("rf_w0", mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0), FRZ);
        cycle("rf_rst", with_rst(mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1)), RSTV);
        check_cnt("rf", 16'd0, 16'd0);
        cycle("rf_run", idle, NORM);
        cycle("rf_lu", lu_s, LU);
        check_cnt("rf_lu", 16'd1, 16'd0);

        // Stall counter saturation under continuous load-use
        cycle("rst4", with_rst(idle), RSTV);
        apply(lu_s);
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", 32'(hif.stall_cnt), 32'h0000_FFFE);
        repeat (3) @(posedge clk);
        #1;
        check("sat_ffff", 32'(hif.stall_cnt), 32'h0000_FFFF);
        cycle("sat_lu", lu_s, LU);
        check_cnt("sat", 16'hFFFF, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 16-bit five-stage MIPS core. It watches the decode stage and the ID/EX register outputs, and drives the write-enables and bubble/flush controls of the PC, IF/ID and ID/EX registers. It resolves three hazards: load-use, taken branch, and multi-cycle data-memory wait. It also keeps saturating performance counters for stall and flush cycles.

## Interface
- `CNT_W`, 16, width of the performance counters
- `clk`  in  1  core clock; state and counters update on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `id_rs`, `id_rt`  in  3 each  source register fields of the instruction in ID
- `id_uses_rs`, `id_uses_rt`  in  1 each  the ID instruction reads that source
- `ex_mem_read`  in  1  `memRead` output of the ID/EX register
- `ex_rt`  in  3  `rt` output of the ID/EX register (load destination)
- `ex_branch_taken`  in  1  branch in EX with its condition true
- `mem_access`  in  1  instruction in MEM performs a load or store
- `mem_ready`  in  1  data memory completes the access this cycle
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`  out  1 each  pipeline register write-enables
- `id_ex_bubble`  out  1  ID/EX captures all-zero control bits
- `if_id_flush`  out  1  IF/ID captures a NOP
- `pc_redirect`  out  1  one-cycle pulse; PC loads the branch target
- `stall_cnt`, `flush_cnt`  out  `CNT_W` each  saturating event counters

## Operation
Derived terms:
- `mem_wait` = `mem_access` & !`mem_ready`
- `load_use` = `ex_mem_read` & `ex_rt`≠0 & ((`id_uses_rs` & `ex_rt`==`id_rs`) | (`id_uses_rt` & `ex_rt`==`id_rt`))
- r0 is hardwired zero and never causes a hazard.

State machine: RUN and FREEZE, plus a `flush_pend` flag.

RUN, in priority order:
1. `mem_wait`:
   - all four enables = 0; no bubble, no flush.
   - `flush_pend` <= `ex_branch_taken`.
   - next state FREEZE.
2. `ex_branch_taken`:
   - all enables = 1, `if_id_flush` = 1, `id_ex_bubble` = 1, `pc_redirect` = 1.
   - `flush_cnt` += 1.
3. `load_use`:
   - `pc_en` = 0, `if_id_en` = 0.
   - `id_ex_en` = 1, `id_ex_bubble` = 1, `ex_mem_en` = 1.
   - `stall_cnt` += 1.
4. Otherwise: all enables = 1, bubble/flush/redirect = 0.

FREEZE:
- While `mem_wait`:
  - all enables = 0, `stall_cnt` += 1.
  - `flush_pend` |= `ex_branch_taken`.
- On `mem_ready`:
  - all enables = 1.
  - If `flush_pend` | `ex_branch_taken`, apply the branch response of RUN step 2 this cycle (one `pc_redirect` pulse), then clear `flush_pend`.
  - `load_use` is not evaluated this cycle.
  - Next state RUN.

Rules:
- The entry cycle into FREEZE counts as a stall (`stall_cnt` += 1).
- Counters saturate at 2^`CNT_W`−1 and never wrap.
- A branch flush overrides a coincident `load_use`. The bubble already covers the younger instruction, so no stall cycle is counted for it.
- `pc_redirect` is asserted at most once per taken branch, even across a multi-cycle freeze.

## Timing
- Outputs are combinational from the state register and the current inputs. They settle in the first half-cycle, before the pipeline registers capture on the falling edge.
- Load-use costs 1 cycle: the bubble enters ID/EX on the same edge at which IF/ID holds. On the next cycle the load is in MEM and `load_use` is false.
- Taken branch costs 2 cycles (IF/ID and ID/EX squashed).
- A memory wait of N cycles with `mem_ready` low freezes for N cycles. Release happens on the cycle `mem_ready` rises.
- While `rst` is high:
  - `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` = 1; `if_id_flush` = 1; `id_ex_bubble` = 1; `pc_redirect` = 0.
  - After the edge: state = RUN, `flush_pend` = 0, both counters = 0.
- Reset asserted in FREEZE returns to RUN on the next edge with no redirect.

## Structure
- Shared core package holds: the FSM state encoding (RUN=0, FREEZE=1), `REG_ZERO`=3'd0, and the register-address width 3.
- Natural sub-module: `sat_counter` (parameter `CNT_W`; ports `clk`, `rst`, `inc`, `count`), instantiated twice.

## Test plan
- Load-use: load to r3 in EX, ID reads rs=3 → exactly 1 cycle of `pc_en`=0 / `if_id_en`=0 / `id_ex_bubble`=1; `stall_cnt`=1.
- Load to r0 with ID rs=0 → no stall; `stall_cnt` stays 0. Load to r3 with ID rt=3 but `id_uses_rt`=0 → no stall.
- Taken branch with a coincident `load_use` → `pc_redirect`, `if_id_flush` and `id_ex_bubble` for 1 cycle, all enables 1; `flush_cnt`=1, `stall_cnt`=0.
- `mem_wait` for 3 cycles → enables 0 for 3 cycles, release on the 4th; `stall_cnt`=3.
- Taken branch arriving during a 2-cycle freeze → exactly one `pc_redirect`, on the release cycle; `flush_cnt`=1.
- Force `stall_cnt` to 0xFFFE plus 3 stalls → reads 0xFFFF. `rst` mid-FREEZE → RUN, counters 0, no redirect.
